// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
//  Module      : im_loader
//  Description : Byte-stream program loader for instruction memory. Packs
//                big-endian 32-bit words, writes them to consecutive word
//                addresses, validates a trailing XOR checksum byte and keeps
//                the CPU held while loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module im_loader #(
    parameter int NMEM  = 128,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] load_len,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             err
);

    localparam int               c_IDX_W = $clog2(NMEM);
    localparam logic [CNT_W-1:0] c_NMEM  = CNT_W'(NMEM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] w_idx_inc;
    logic [1:0]       r_bcnt;
    logic [23:0]      r_shift;
    logic [7:0]       r_cks;
    logic             r_wr_en;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_wr_data;
    logic             r_hold;
    logic             r_done;
    logic             r_err;
    logic             w_ready;
    logic             w_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_idx_inc   = r_idx + CNT_W'(1);
        case (r_state)
            S_IDLE: begin
                if (start && (load_len != '0) && (load_len <= c_NMEM))
                    w_state_nxt = S_RECV;
            end
            S_RECV: begin
                w_ready = 1'b1;
                if (in_valid && (r_bcnt == 2'd3))
                    w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_state_nxt = (w_idx_inc == r_len) ? S_CHECK : S_RECV;
            end
            S_CHECK: begin
                w_ready = 1'b1;
                if (in_valid)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_xfer = in_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len     <= '0;
            r_idx     <= '0;
            r_bcnt    <= '0;
            r_shift   <= '0;
            r_cks     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_hold    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                        r_len  <= load_len;
                        if (load_len == '0) begin
                            r_done <= 1'b1;
                        end else if (load_len > c_NMEM) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_hold <= 1'b1;
                            r_cks  <= '0;
                            r_idx  <= '0;
                            r_bcnt <= '0;
                        end
                    end
                end
                S_RECV: begin
                    if (w_xfer) begin
                        r_shift <= {r_shift[15:0], in_data};
                        r_cks   <= r_cks ^ in_data;
                        r_bcnt  <= r_bcnt + 2'd1;
                        // Fourth byte: launch the write so it is visible during WRITE.
                        if (r_bcnt == 2'd3) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= {{(30-c_IDX_W){1'b0}}, r_idx[c_IDX_W-1:0], 2'b00};
                            r_wr_data <= {r_shift, in_data};
                        end
                    end
                end
                S_WRITE: begin
                    // Index stops at the last written word so it stays below NMEM.
                    if (w_idx_inc != r_len)
                        r_idx <= w_idx_inc;
                end
                S_CHECK: begin
                    if (w_xfer) begin
                        r_err  <= (in_data != r_cks);
                        r_done <= 1'b1;
                        r_hold <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready = w_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cpu_hold = r_hold;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire
